// File: rtl/dram_resp.sv
// Memory-side responder for the conv controller's DRAM port: word-addressed store
// with a host preload/readback port and a fixed 1-cycle accelerator read path.
module dram_resp #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 18,
   parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = ADDR_WIDTH'(131072)
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  accel_start,
   input  logic                  accel_done,
   input  logic                  dram_en_rd,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  dram_en_wr,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_gnt,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  host_rvalid,
   output logic                  busy,
   output logic                  err,
   output logic [23:0]           rd_cnt,
   output logic [23:0]           wr_cnt
);

   localparam int             CNT_W   = 24;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_HOST,
      ST_ACCEL,
      ST_DRAIN
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Per-state access qualifiers
   logic w_acc_rd;
   logic w_acc_wr;
   logic w_host_rd;
   logic w_host_wr;
   logic w_stray;

   // Store port signals
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_waddr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;
   logic [ADDR_WIDTH-1:0] w_mem_raddr;
   logic                  w_fwd;
   logic                  w_low_wr;

   logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] r_mem_q;

   // Read-return pipeline and hold registers
   logic                  r_acc_rd_q;
   logic                  r_fwd_q;
   logic [DATA_WIDTH-1:0] r_fwd_data_q;
   logic [DATA_WIDTH-1:0] r_rd_hold;
   logic                  r_host_rd_q;
   logic [DATA_WIDTH-1:0] r_host_hold;

   logic                  r_err;
   logic [CNT_W-1:0]      r_rd_cnt;
   logic [CNT_W-1:0]      r_wr_cnt;

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_state <= ST_HOST;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Start has priority over done while the host owns the store.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_HOST:  if (accel_start) w_next_state = ST_ACCEL;
         ST_ACCEL: if (accel_done)  w_next_state = ST_DRAIN;
         ST_DRAIN: w_next_state = ST_HOST;
         default:  w_next_state = ST_HOST;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      busy      = 1'b0;
      host_gnt  = 1'b0;
      w_acc_rd  = 1'b0;
      w_acc_wr  = 1'b0;
      w_host_rd = 1'b0;
      w_host_wr = 1'b0;
      w_stray   = 1'b0;
      case (r_state)
         ST_HOST: begin
            host_gnt  = host_req;
            w_host_wr = host_req & host_we;
            w_host_rd = host_req & ~host_we;
            w_stray   = dram_en_rd | dram_en_wr;
         end
         ST_ACCEL: begin
            busy     = 1'b1;
            w_acc_rd = dram_en_rd;
            w_acc_wr = dram_en_wr;
         end
         ST_DRAIN: begin
            busy     = 1'b1;
            w_acc_wr = dram_en_wr;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------- store
   // Host and accelerator never own the store in the same state, so one write
   // port and one read port suffice.
   assign w_mem_we    = ~srst & (w_host_wr | w_acc_wr);
   assign w_mem_waddr = w_acc_wr ? addr_out : host_addr;
   assign w_mem_wdata = w_acc_wr ? wr_data  : host_wdata;
   assign w_mem_raddr = w_acc_rd ? addr_in  : host_addr;

   assign w_fwd    = w_acc_rd & w_acc_wr & (addr_in == addr_out);
   assign w_low_wr = w_acc_wr & (addr_out < OFMAP_BASE);

   // NOTE: the store array is deliberately left out of reset so contents survive srst
   // and the array can map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
      r_mem_q <= r_mem[w_mem_raddr];
   end

   // ---------------------------------------------------------------- read return
   always_ff @(posedge clk) begin
      if (srst) begin
         r_acc_rd_q   <= 1'b0;
         r_fwd_q      <= 1'b0;
         r_fwd_data_q <= '0;
         r_rd_hold    <= '0;
         r_host_rd_q  <= 1'b0;
         r_host_hold  <= '0;
      end else begin
         r_acc_rd_q  <= w_acc_rd;
         r_fwd_q     <= w_fwd;
         r_host_rd_q <= w_host_rd;
         r_rd_hold   <= rd_data;
         r_host_hold <= host_rdata;
         if (w_fwd) begin
            r_fwd_data_q <= wr_data;
         end
      end
   end

   // Fresh data in the cycle after a read, otherwise the last returned word is held.
   assign rd_data     = r_acc_rd_q  ? (r_fwd_q ? r_fwd_data_q : r_mem_q) : r_rd_hold;
   assign host_rdata  = r_host_rd_q ? r_mem_q : r_host_hold;
   assign host_rvalid = r_host_rd_q;

   // ---------------------------------------------------------------- status
   always_ff @(posedge clk) begin
      if (srst) begin
         r_err <= 1'b0;
      end else if (w_stray | w_low_wr) begin
         r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else if ((r_state == ST_HOST) && accel_start) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_acc_rd && (r_rd_cnt != CNT_MAX)) r_rd_cnt <= r_rd_cnt + 1'b1;
         if (w_acc_wr && (r_wr_cnt != CNT_MAX)) r_wr_cnt <= r_wr_cnt + 1'b1;
      end
   end

   assign err    = r_err;
   assign rd_cnt = r_rd_cnt;
   assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp: expected read data is queued when a read is
// issued and compared when the response is due.
module tb_dram_resp;

   localparam int DW = 32;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          srst = 1'b0;
   logic          accel_start = 1'b0;
   logic          accel_done = 1'b0;
   logic          dram_en_rd = 1'b0;
   logic [AW-1:0] addr_in = '0;
   logic [DW-1:0] rd_data;
   logic          dram_en_wr = 1'b0;
   logic [AW-1:0] addr_out = '0;
   logic [DW-1:0] wr_data = '0;
   logic          host_req = 1'b0;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_gnt;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic          busy;
   logic          err;
   logic [23:0]   rd_cnt;
   logic [23:0]   wr_cnt;

   always #5 clk = ~clk;

   dram_resp #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .OFMAP_BASE(18'd131072)
   ) dut (
      .clk        (clk),
      .srst       (srst),
      .accel_start(accel_start),
      .accel_done (accel_done),
      .dram_en_rd (dram_en_rd),
      .addr_in    (addr_in),
      .rd_data    (rd_data),
      .dram_en_wr (dram_en_wr),
      .addr_out   (addr_out),
      .wr_data    (wr_data),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_gnt   (host_gnt),
      .host_rdata (host_rdata),
      .host_rvalid(host_rvalid),
      .busy       (busy),
      .err        (err),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt)
   );

   typedef struct {
      string         tag;
      logic [DW-1:0] exp;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] model [int];
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_check(input logic [DW-1:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.exp);
      end
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      #1;
      check("host_gnt_wr", 32'(host_gnt), 32'd1);
      tick();
      host_req = 1'b0; host_we = 1'b0;
      model[int'(a)] = d;
   endtask

   task automatic host_read(input logic [AW-1:0] a);
      host_req = 1'b1; host_we = 1'b0; host_addr = a;
      #1;
      check("host_gnt_rd", 32'(host_gnt), 32'd1);
      sb_q.push_back('{"host_rdata", model[int'(a)]});
      tick();
      host_req = 1'b0;
      check("host_rvalid", 32'(host_rvalid), 32'd1);
      sb_check(host_rdata);
   endtask

   // One accelerator cycle: optional read and/or write, read result checked next cycle.
   task automatic acc_op(input logic rd, input logic [AW-1:0] ra,
                         input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      dram_en_rd = rd; addr_in = ra;
      dram_en_wr = wr; addr_out = wa; wr_data = wd;
      if (rd) sb_q.push_back('{"rd_data", (wr && wa == ra) ? wd : model[int'(ra)]});
      tick();
      dram_en_rd = 1'b0; dram_en_wr = 1'b0;
      if (wr) model[int'(wa)] = wd;
      if (rd) sb_check(rd_data);
   endtask

   task automatic pulse_start();
      accel_start = 1'b1; tick(); accel_start = 1'b0;
   endtask

   task automatic pulse_done();
      accel_done = 1'b1; tick(); accel_done = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      srst = 1'b1;
      tick(); tick();
      srst = 1'b0;
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_host_rdata", host_rdata, 32'd0);
      check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
      check("rst_host_gnt", 32'(host_gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
      check("rst_wr_cnt", 32'(wr_cnt), 32'd0);

      // Host write/read round trip, rvalid is a single pulse
      host_write(18'd5, 32'hA5);
      host_read(18'd5);
      tick();
      check("host_rvalid_pulse", 32'(host_rvalid), 32'd0);
      host_write(18'd65536, 32'd7);
      host_write(18'd131072, 32'h99);

      // First accelerator session
      pulse_start();
      check("busy_accel", 32'(busy), 32'd1);
      host_req = 1'b1; host_we = 1'b1; host_addr = 18'd5; host_wdata = 32'hDEAD;
      #1;
      check("host_gnt_held_off", 32'(host_gnt), 32'd0);
      tick();
      host_req = 1'b0; host_we = 1'b0;
      acc_op(1'b1, 18'd65536, 1'b0, '0, '0);
      tick();
      check("rd_data_hold", rd_data, 32'd7);
      acc_op(1'b1, 18'd131072, 1'b1, 18'd131072, 32'h10);
      acc_op(1'b1, 18'd131072, 1'b0, '0, '0);
      acc_op(1'b0, '0, 1'b1, 18'd131100, 32'h55);
      acc_op(1'b1, 18'd131100, 1'b0, '0, '0);
      check("err_clean", 32'(err), 32'd0);
      acc_op(1'b0, '0, 1'b1, 18'd64, 32'h64);
      check("err_low_write", 32'(err), 32'd1);
      check("rd_cnt_s1", 32'(rd_cnt), 32'd4);
      check("wr_cnt_s1", 32'(wr_cnt), 32'd3);
      pulse_done();
      check("busy_drain", 32'(busy), 32'd1);
      tick();
      check("busy_back_host", 32'(busy), 32'd0);
      check("err_sticky", 32'(err), 32'd1);
      host_read(18'd5);
      host_read(18'd131072);
      host_read(18'd131100);
      host_read(18'd64);

      // Second session: counters restart, drain-cycle write completes
      pulse_start();
      check("rd_cnt_clear", 32'(rd_cnt), 32'd0);
      check("wr_cnt_clear", 32'(wr_cnt), 32'd0);
      acc_op(1'b1, 18'd131072, 1'b0, '0, '0);
      acc_op(1'b0, '0, 1'b1, 18'd131300, 32'h1);
      acc_op(1'b1, 18'd131100, 1'b0, '0, '0);
      acc_op(1'b0, '0, 1'b1, 18'd131301, 32'h2);
      acc_op(1'b1, 18'd65536, 1'b0, '0, '0);
      pulse_done();
      check("rd_cnt_s2", 32'(rd_cnt), 32'd3);
      check("wr_cnt_s2", 32'(wr_cnt), 32'd2);
      check("busy_drain2", 32'(busy), 32'd1);
      acc_op(1'b0, '0, 1'b1, 18'd131400, 32'h77);
      check("busy_host2", 32'(busy), 32'd0);
      check("wr_cnt_drain", 32'(wr_cnt), 32'd3);
      host_read(18'd131400);
      host_read(18'd131301);

      // Reset in the middle of a session
      pulse_start();
      acc_op(1'b1, 18'd65536, 1'b0, '0, '0);
      acc_op(1'b0, '0, 1'b1, 18'd131500, 32'hBEEF);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      check("srst_busy", 32'(busy), 32'd0);
      check("srst_err", 32'(err), 32'd0);
      check("srst_rd_data", rd_data, 32'd0);
      check("srst_rd_cnt", 32'(rd_cnt), 32'd0);
      check("srst_wr_cnt", 32'(wr_cnt), 32'd0);
      host_read(18'd131500);
      host_read(18'd65536);

      // Stray accelerator read while the host owns the store
      dram_en_rd = 1'b1; addr_in = 18'd65536;
      tick();
      dram_en_rd = 1'b0;
      check("stray_err", 32'(err), 32'd1);
      check("stray_rd_data", rd_data, 32'd0);

      // Start and done together: start wins
      accel_start = 1'b1; accel_done = 1'b1;
      tick();
      accel_start = 1'b0; accel_done = 1'b0;
      check("start_wins", 32'(busy), 32'd1);
      tick();
      check("start_wins_stay", 32'(busy), 32'd1);
      pulse_done();
      tick();
      check("final_host", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
